// File: rtl/seq_shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier: WIDTH x WIDTH -> 2*WIDTH.
// One partial-product addition per cycle through a ripple-carry full-adder chain.
module seq_shift_add_multiplier #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam int unsigned PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [WIDTH-1:0] mcand, mcand_n;
    logic [WIDTH-1:0] hi, hi_n;
    logic [WIDTH-1:0] lo, lo_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [PW-1:0]    product_n;

    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] sum;
    logic             cout;

    // One full-adder cell: returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        full_add = {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
    endfunction

    // Ripple-carry adder stage: hi + (lo[0] ? mcand : 0), carry-in 0.
    always_comb begin
        logic       c;
        logic [1:0] fa;
        addend = lo[0] ? mcand : '0;
        sum    = '0;
        c      = 1'b0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            fa     = full_add(hi[i], addend[i], c);
            sum[i] = fa[0];
            c      = fa[1];
        end
        cout = c;
    end

    // Next-state and datapath next values.
    always_comb begin
        state_n   = state;
        mcand_n   = mcand;
        hi_n      = hi;
        lo_n      = lo;
        cnt_n     = cnt;
        product_n = product;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_CALC;
                    mcand_n = a;
                    lo_n    = b;
                    hi_n    = '0;
                    cnt_n   = '0;
                end
            end
            S_CALC: begin
                // {cout,sum,lo} shifted right by one: product bit falls into lo MSB.
                hi_n  = {cout, sum[WIDTH-1:1]};
                lo_n  = {sum[0], lo[WIDTH-1:1]};
                cnt_n = cnt + CW'(1);
                if (cnt == CW'(WIDTH - 1)) begin
                    state_n   = S_DONE;
                    product_n = {hi_n, lo_n};
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            mcand   <= '0;
            hi      <= '0;
            lo      <= '0;
            cnt     <= '0;
            product <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            mcand   <= mcand_n;
            hi      <= hi_n;
            lo      <= lo_n;
            cnt     <= cnt_n;
            product <= product_n;
            busy    <= (state_n != S_IDLE);
            done    <= (state_n == S_DONE);
        end
    end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Scoreboard bench for seq_shift_add_multiplier (WIDTH=4).
module tb_seq_shift_add_multiplier;

    localparam int unsigned W  = 4;
    localparam int unsigned PW = 2 * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          busy;
    logic          done;
    logic [PW-1:0] product;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [PW-1:0] sb_q[$];
    logic          spacing_on = 1'b0;
    logic          stim_done  = 1'b0;

    typedef struct {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [PW-1:0] exp;
    } vec_t;

    seq_shift_add_multiplier #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for IDLE.
    task automatic wait_idle();
        for (int t = 0; t < 20 && busy; t++) step();
        check("wait_idle", 32'(busy), 0);
    endtask

    // One operation with a single-cycle start; checks busy/done every cycle.
    task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic [PW-1:0] exp);
        a = va; b = vb; start = 1'b1;
        sb_q.push_back(exp);
        check("c0_busy", 32'(busy), 0);
        for (int k = 1; k <= int'(W) + 2; k++) begin
            step();
            start = 1'b0;
            a = ~va; b = ~vb;
            check($sformatf("c%0d_busy", k), 32'(busy), (k <= int'(W) + 1) ? 1 : 0);
            check($sformatf("c%0d_done", k), 32'(done), (k == int'(W) + 1) ? 1 : 0);
            if (k >= int'(W) + 1) check($sformatf("c%0d_product", k), 32'(product), 32'(exp));
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse; checks done spacing when enabled.
    initial begin
        int unsigned cyc = 0;
        int unsigned last = 0;
        logic have_prev = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (done) begin
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_done: got product %0d, want no done", product);
                end else begin
                    logic [PW-1:0] e;
                    e = sb_q.pop_front();
                    check("sb_product", 32'(product), 32'(e));
                end
                if (spacing_on && have_prev) check("done_spacing", cyc - last, W + 2);
                have_prev = spacing_on;
                last = cyc;
            end
        end
    end

    initial begin
        vec_t dir[$];
        dir.push_back('{4'd4,  4'd4,  8'd16});
        dir.push_back('{4'd15, 4'd15, 8'd225});
        dir.push_back('{4'd15, 4'd1,  8'd15});
        dir.push_back('{4'd1,  4'd15, 8'd15});
        dir.push_back('{4'd0,  4'd13, 8'd0});
        dir.push_back('{4'd11, 4'd0,  8'd0});
        dir.push_back('{4'd10, 4'd12, 8'd120});
        dir.push_back('{4'd7,  4'd13, 8'd91});

        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (3) step();
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_product", 32'(product), 0);
        rst = 1'b0;
        step();

        // Directed vectors with full per-cycle timing checks.
        foreach (dir[i]) run_op(dir[i].a, dir[i].b, dir[i].exp);

        // Start ignored while CALC/DONE; product held until next completion.
        wait_idle();
        a = 4'd6; b = 4'd7; start = 1'b1; sb_q.push_back(8'd42);     // cycle 0
        step(); start = 1'b0;                                          // cycle 1
        step(); start = 1'b1; a = 4'd3; b = 4'd3;                      // cycle 2
        step(); start = 1'b0;                                          // cycle 3
        step();                                                        // cycle 4
        step(); start = 1'b1; a = 4'd3; b = 4'd3;                      // cycle 5
        check("ign_c5_done", 32'(done), 1);
        check("ign_c5_product", 32'(product), 42);
        step(); a = 4'd5; b = 4'd5; sb_q.push_back(8'd25);             // cycle 6
        check("ign_c6_busy", 32'(busy), 0);
        for (int k = 6; k <= 10; k++) begin
            if (k > 6) step();
            if (k == 7) start = 1'b0;
            check($sformatf("ign_c%0d_hold", k), 32'(product), 42);
        end
        step();                                                        // cycle 11
        check("ign_c11_done", 32'(done), 1);
        check("ign_c11_product", 32'(product), 25);

        // Reset mid-operation abandons the multiply.
        wait_idle();
        a = 4'd9; b = 4'd9; start = 1'b1;                              // cycle 0
        step(); start = 1'b0;                                          // cycle 1
        step(); rst = 1'b1;                                            // cycle 2
        step(); rst = 1'b0;                                            // cycle 3
        check("mrst_busy", 32'(busy), 0);
        check("mrst_done", 32'(done), 0);
        check("mrst_product", 32'(product), 0);
        repeat (8) step();
        check("mrst_product_after", 32'(product), 0);
        run_op(4'd7, 4'd9, 8'd63);

        // Exhaustive, start held high, back-to-back operations.
        wait_idle();
        spacing_on = 1'b1;
        start = 1'b1;
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                wait_idle();
                a = W'(ia); b = W'(ib);
                sb_q.push_back(PW'(ia * ib));
                step();
                a = '0; b = '0;
            end
        end
        for (int t = 0; t < int'(W) + 1 && !done; t++) step();
        start = 1'b0;
        for (int t = 0; t < 20 && sb_q.size() != 0; t++) step();
        repeat (2) step();
        check("sb_drained", sb_q.size(), 0);
        stim_done = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        if (!stim_done) begin
            $display("FAIL watchdog: got timeout, want completion");
            $fatal(1, "timeout");
        end
    end

endmodule
